// File: rtl/ahb_pkg.sv
// Shared AHB definitions for the SRAM slave: bus defaults, transfer/response
// encodings, slave FSM states and the byte-lane decode helper.
package ahb_pkg;

  localparam int AHB_ADDR_WIDTH = 20;
  localparam int AHB_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_t;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_t;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_t;

  // Little-endian lane mask; callers reject misaligned/oversized transfers first.
  function automatic logic [3:0] lane_enable(input logic [1:0] addr_lo, input logic [2:0] size);
    case (size)
      HSIZE_BYTE: lane_enable = 4'b0001 << addr_lo;
      HSIZE_HALF: lane_enable = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:    lane_enable = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ahb_slave_mem.sv
// Word-wide SRAM with per-byte write enables and combinational read on a
// single shared address.
module ahb_slave_mem
  import ahb_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int IDX_W = 10
) (
  input  logic             clk,
  input  logic [3:0]       lanes,
  input  logic [IDX_W-1:0] addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (lanes[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB SRAM slave with configurable wait states, address/size checking and
// per-lane write parity checking; errors use the two-cycle ERROR response.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH  = AHB_ADDR_WIDTH,
  parameter int DATA_WIDTH  = AHB_DATA_WIDTH,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic [3:0]            HWDATACHK,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HREADY,
  output logic                  HRSP
);

  localparam int         IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0] WAIT_INIT = 3'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [3:0]       lanes_reg, lanes_next;
  logic             write_reg, write_next;
  logic [2:0]       wait_reg, wait_next;
  logic [31:0]      rdata_reg;

  logic [ADDR_WIDTH-3:0] word_idx;
  logic        accept, addr_err, parity_err, data_read;
  logic [3:0]  lane_bad, mem_lanes;
  logic [31:0] mem_rdata;

  assign accept   = HREADY && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
  assign word_idx = HADDR[ADDR_WIDTH-1:2];
  assign addr_err = (64'(word_idx) >= 64'(DEPTH)) || (HSIZE > HSIZE_WORD) ||
                    (HSIZE == HSIZE_HALF && HADDR[0]) ||
                    (HSIZE == HSIZE_WORD && HADDR[1:0] != 2'b00);

  // Lanes outside the transfer carry don't-care data, so their parity is ignored.
  for (genvar gi = 0; gi < 4; gi++) begin : g_parity
    assign lane_bad[gi] = lanes_reg[gi] & (HWDATACHK[gi] ^ (^HWDATA[8*gi +: 8]));
  end
  assign parity_err = write_reg && (lane_bad != 4'b0000);

  // A parity fault turns the DATA cycle into the first ERROR cycle.
  always_comb begin
    HREADY = 1'b1;
    HRSP   = HRESP_OKAY;
    case (state_reg)
      ST_WAIT: HREADY = 1'b0;
      ST_DATA: if (parity_err) begin
        HREADY = 1'b0;
        HRSP   = HRESP_ERROR;
      end
      ST_ERR1: begin
        HREADY = 1'b0;
        HRSP   = HRESP_ERROR;
      end
      ST_ERR2: HRSP = HRESP_ERROR;
      default: ;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    lanes_next = lanes_reg;
    write_next = write_reg;
    wait_next  = wait_reg;
    case (state_reg)
      ST_WAIT: if (wait_reg == 3'd0) state_next = ST_DATA;
               else wait_next = wait_reg - 3'd1;
      ST_ERR1: state_next = ST_ERR2;
      default: state_next = ST_IDLE;
    endcase
    if (state_reg == ST_DATA && parity_err) begin
      state_next = ST_ERR2;
    end else if (accept) begin
      idx_next   = HADDR[IDX_W+1:2];
      lanes_next = lane_enable(HADDR[1:0], HSIZE);
      write_next = HWRITE;
      if (addr_err) begin
        state_next = ST_ERR1;
      end else if (WAIT_STATES > 0) begin
        state_next = ST_WAIT;
        wait_next  = WAIT_INIT;
      end else begin
        state_next = ST_DATA;
      end
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_reg <= ST_IDLE;
      idx_reg   <= '0;
      lanes_reg <= 4'b0000;
      write_reg <= 1'b0;
      wait_reg  <= 3'd0;
      rdata_reg <= 32'h0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      lanes_reg <= lanes_next;
      write_reg <= write_next;
      wait_reg  <= wait_next;
      if (data_read) rdata_reg <= mem_rdata;
    end
  end

  assign data_read = (state_reg == ST_DATA) && !write_reg;
  assign mem_lanes = (state_reg == ST_DATA && write_reg && !parity_err) ? lanes_reg : 4'b0000;
  // Read straight from the array in DATA so a preceding back-to-back write is visible.
  assign HRDATA    = data_read ? mem_rdata : rdata_reg;

  ahb_slave_mem #(
    .DEPTH(DEPTH),
    .IDX_W(IDX_W)
  ) u_mem (
    .clk  (HCLK),
    .lanes(mem_lanes),
    .addr (idx_reg),
    .wdata(HWDATA),
    .rdata(mem_rdata)
  );

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave: one instance with one wait state and one
// zero-wait instance for back-to-back pipelining.
module tb_ahb_sram_slave;

  logic        HCLK = 1'b0;
  logic        HRESET;
  always #5 HCLK = ~HCLK;

  logic [19:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic [3:0]  HWDATACHK;
  logic [31:0] HRDATA;
  logic        HREADY, HRSP;

  logic [19:0] z_haddr;
  logic [1:0]  z_htrans;
  logic        z_hwrite;
  logic [2:0]  z_hsize;
  logic [31:0] z_hwdata;
  logic [3:0]  z_hwdatachk;
  logic [31:0] z_hrdata;
  logic        z_hready, z_hrsp;

  int checks = 0;
  int errors = 0;

  ahb_sram_slave #(.ADDR_WIDTH(20), .DATA_WIDTH(32), .DEPTH(1024), .WAIT_STATES(1)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HWDATA(HWDATA), .HWDATACHK(HWDATACHK), .HRDATA(HRDATA),
    .HREADY(HREADY), .HRSP(HRSP)
  );

  ahb_sram_slave #(.ADDR_WIDTH(20), .DATA_WIDTH(32), .DEPTH(1024), .WAIT_STATES(0)) dut0 (
    .HCLK(HCLK), .HRESET(HRESET), .HADDR(z_haddr), .HTRANS(z_htrans), .HWRITE(z_hwrite),
    .HSIZE(z_hsize), .HWDATA(z_hwdata), .HWDATACHK(z_hwdatachk), .HRDATA(z_hrdata),
    .HREADY(z_hready), .HRSP(z_hrsp)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  function automatic logic [3:0] par(input logic [31:0] d);
    par = {^d[31:24], ^d[23:16], ^d[15:8], ^d[7:0]};
  endfunction

  // One isolated transfer on the WAIT_STATES=1 instance; entered and left at posedge+1.
  task automatic xfer(input string tag, input logic [19:0] a, input logic w, input logic [2:0] sz,
                      input logic [31:0] wd, input logic [3:0] chk, input int waits,
                      input logic err, input logic [31:0] rd);
    HTRANS = 2'd2; HADDR = a; HWRITE = w; HSIZE = sz;
    @(posedge HCLK); #1;
    HTRANS = 2'd0; HWDATA = wd; HWDATACHK = chk;
    for (int i = 0; i < waits; i++) begin
      @(negedge HCLK);
      check({tag, ".wait_rdy"}, 32'(HREADY), 32'd0);
      check({tag, ".wait_rsp"}, 32'(HRSP), 32'd0);
      @(posedge HCLK); #1;
    end
    if (err) begin
      @(negedge HCLK);
      check({tag, ".err1_rdy"}, 32'(HREADY), 32'd0);
      check({tag, ".err1_rsp"}, 32'(HRSP), 32'd1);
      @(posedge HCLK); #1;
      @(negedge HCLK);
      check({tag, ".err2_rdy"}, 32'(HREADY), 32'd1);
      check({tag, ".err2_rsp"}, 32'(HRSP), 32'd1);
    end else begin
      @(negedge HCLK);
      check({tag, ".data_rdy"}, 32'(HREADY), 32'd1);
      check({tag, ".data_rsp"}, 32'(HRSP), 32'd0);
      if (!w) check({tag, ".rdata"}, HRDATA, rd);
    end
    @(posedge HCLK); #1;
  endtask

  initial begin
    HRESET = 1'b1;
    HADDR = '0; HTRANS = 2'd0; HWRITE = 1'b0; HSIZE = 3'd2; HWDATA = '0; HWDATACHK = '0;
    z_haddr = '0; z_htrans = 2'd0; z_hwrite = 1'b0; z_hsize = 3'd2; z_hwdata = '0; z_hwdatachk = '0;
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    check("reset.rdy", 32'(HREADY), 32'd1);
    check("reset.rsp", 32'(HRSP), 32'd0);
    check("reset.rdata", HRDATA, 32'h0);
    check("reset0.rdy", 32'(z_hready), 32'd1);
    HRESET = 1'b0;
    @(posedge HCLK); #1;

    xfer("wr_deadbeef", 20'h00010, 1'b1, 3'd2, 32'hDEADBEEF, par(32'hDEADBEEF), 1, 1'b0, 32'h0);
    xfer("rd_deadbeef", 20'h00010, 1'b0, 3'd2, 32'h0, 4'h0, 1, 1'b0, 32'hDEADBEEF);
    @(negedge HCLK);
    check("hold.rdata", HRDATA, 32'hDEADBEEF);
    @(posedge HCLK); #1;

    xfer("wr_11223344", 20'h00010, 1'b1, 3'd2, 32'h11223344, par(32'h11223344), 1, 1'b0, 32'h0);
    xfer("wr_byte_aa", 20'h00013, 1'b1, 3'd0, 32'hAA000000, par(32'hAA000000), 1, 1'b0, 32'h0);
    xfer("rd_aa223344", 20'h00010, 1'b0, 3'd2, 32'h0, 4'h0, 1, 1'b0, 32'hAA223344);
    xfer("wr_half_5566", 20'h00012, 1'b1, 3'd1, 32'h55660000, par(32'h55660000), 1, 1'b0, 32'h0);
    xfer("rd_byte_55663344", 20'h00011, 1'b0, 3'd0, 32'h0, 4'h0, 1, 1'b0, 32'h55663344);

    xfer("wr_0badf00d", 20'h00020, 1'b1, 3'd2, 32'h0BADF00D, par(32'h0BADF00D), 1, 1'b0, 32'h0);
    xfer("wr_parity_bad", 20'h00020, 1'b1, 3'd2, 32'hCAFEBABE, par(32'hCAFEBABE) ^ 4'b0001, 1, 1'b1, 32'h0);
    xfer("rd_after_parity", 20'h00020, 1'b0, 3'd2, 32'h0, 4'h0, 1, 1'b0, 32'h0BADF00D);
    xfer("wr_byte_badchk_idle_lane", 20'h00021, 1'b1, 3'd0, 32'h00007700, par(32'h00007700) ^ 4'b0001, 1, 1'b0, 32'h0);
    xfer("rd_0bad770d", 20'h00020, 1'b0, 3'd2, 32'h0, 4'h0, 1, 1'b0, 32'h0BAD770D);

    xfer("rd_range", 20'h01000, 1'b0, 3'd2, 32'h0, 4'h0, 0, 1'b1, 32'h0);
    xfer("wr_range", 20'h01000, 1'b1, 3'd2, 32'h12345678, par(32'h12345678), 0, 1'b1, 32'h0);
    xfer("rd_half_misalign", 20'h00001, 1'b0, 3'd1, 32'h0, 4'h0, 0, 1'b1, 32'h0);
    xfer("rd_size3", 20'h00000, 1'b0, 3'd3, 32'h0, 4'h0, 0, 1'b1, 32'h0);
    xfer("rd_last_word", 20'h00FFC, 1'b0, 3'd2, 32'h0, 4'h0, 1, 1'b0, 32'hx);

    // Zero-wait instance: write then read of the same word with no idle cycle.
    z_htrans = 2'd2; z_haddr = 20'h00040; z_hwrite = 1'b1; z_hsize = 3'd2;
    @(posedge HCLK); #1;
    z_hwdata = 32'h600DCAFE; z_hwdatachk = par(32'h600DCAFE);
    z_htrans = 2'd2; z_haddr = 20'h00040; z_hwrite = 1'b0;
    @(negedge HCLK);
    check("b2b.wr_rdy", 32'(z_hready), 32'd1);
    check("b2b.wr_rsp", 32'(z_hrsp), 32'd0);
    @(posedge HCLK); #1;
    z_htrans = 2'd0;
    @(negedge HCLK);
    check("b2b.rd_rdy", 32'(z_hready), 32'd1);
    check("b2b.rd_rdata", z_hrdata, 32'h600DCAFE);
    @(posedge HCLK); #1;

    // Address error followed by a read that is held through ERR1 and taken in ERR2.
    z_htrans = 2'd2; z_haddr = 20'h01000; z_hwrite = 1'b0;
    @(posedge HCLK); #1;
    z_htrans = 2'd3; z_haddr = 20'h00040;
    @(negedge HCLK);
    check("err_b2b.err1_rdy", 32'(z_hready), 32'd0);
    check("err_b2b.err1_rsp", 32'(z_hrsp), 32'd1);
    @(posedge HCLK); #1;
    @(negedge HCLK);
    check("err_b2b.err2_rdy", 32'(z_hready), 32'd1);
    check("err_b2b.err2_rsp", 32'(z_hrsp), 32'd1);
    @(posedge HCLK); #1;
    z_htrans = 2'd0;
    @(negedge HCLK);
    check("err_b2b.data_rdy", 32'(z_hready), 32'd1);
    check("err_b2b.data_rsp", 32'(z_hrsp), 32'd0);
    check("err_b2b.rdata", z_hrdata, 32'h600DCAFE);
    @(posedge HCLK); #1;

    // Reset in the WAIT cycle of a write must drop the write.
    xfer("wr_12345678", 20'h00030, 1'b1, 3'd2, 32'h12345678, par(32'h12345678), 1, 1'b0, 32'h0);
    HTRANS = 2'd2; HADDR = 20'h00030; HWRITE = 1'b1; HSIZE = 3'd2;
    @(posedge HCLK); #1;
    HTRANS = 2'd0; HWDATA = 32'hFFFFFFFF; HWDATACHK = par(32'hFFFFFFFF);
    check("rst_wait.rdy_before", 32'(HREADY), 32'd0);
    HRESET = 1'b1;
    #1;
    check("rst_wait.rdy", 32'(HREADY), 32'd1);
    check("rst_wait.rsp", 32'(HRSP), 32'd0);
    check("rst_wait.rdata", HRDATA, 32'h0);
    @(posedge HCLK);
    @(negedge HCLK);
    HRESET = 1'b0;
    @(posedge HCLK); #1;
    xfer("rd_after_reset", 20'h00030, 1'b0, 3'd2, 32'h0, 4'h0, 1, 1'b0, 32'h12345678);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_sram_slave.md
AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 20, HADDR width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, bus data width (only 32 supported).
REQ-003 SHALL have parameter DEPTH, default 1024, number of 32-bit memory words.
REQ-004 SHALL have parameter WAIT_STATES, default 1, wait cycles per data phase (range 0..7).
REQ-005 SHALL have port HCLK  input  1  sole clock, rising edge.
REQ-006 SHALL have port HRESET  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port HADDR  input  ADDR_WIDTH  byte address.
REQ-008 SHALL have port HTRANS  input  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
REQ-009 SHALL have port HWRITE  input  1  1=write.
REQ-010 SHALL have port HSIZE  input  3  0=byte, 1=halfword, 2=word.
REQ-011 SHALL have port HWDATA  input  DATA_WIDTH  write data, data phase.
REQ-012 SHALL have port HWDATACHK  input  4  per-byte even parity of HWDATA.
REQ-013 SHALL have port HRDATA  output  DATA_WIDTH  read data.
REQ-014 SHALL have port HREADY  output  1  transfer complete/ready.
REQ-015 SHALL have port HRSP  output  1  0=OKAY, 1=ERROR.

Function
REQ-016 SHALL sample an address phase (HADDR, HWRITE, HSIZE) only on a rising edge where HTRANS is NONSEQ or SEQ and HREADY=1.
REQ-017 SHALL use FSM states IDLE, WAIT, DATA, ERR1, ERR2; IDLE -> WAIT (WAIT_STATES>0) or DATA (WAIT_STATES=0) on accepted transfer.
REQ-018 SHALL drive HREADY=0, HRSP=0 for exactly WAIT_STATES cycles (WAIT), then one DATA cycle with HREADY=1.
REQ-019 SHALL treat IDLE/BUSY transfers as zero-wait OKAY with no memory access.
REQ-020 SHALL flag error when word index HADDR[ADDR_WIDTH-1:2] >= DEPTH, HSIZE>2, or address misaligned for HSIZE; checked at address sampling.
REQ-021 SHALL check write parity in the DATA cycle on active byte lanes only: HWDATACHK[i] must equal XOR of HWDATA[8i+7:8i].
REQ-022 SHALL on any error signal ERR1 (HREADY=0, HRSP=1) then ERR2 (HREADY=1, HRSP=1), suppressing the write; address errors skip WAIT.
REQ-023 SHALL commit writes at the end of the DATA cycle, little-endian byte-lane enables from HADDR[1:0] and HSIZE.
REQ-024 SHALL present the full addressed word on HRDATA in the DATA cycle of a read; HRDATA holds its last value otherwise.
REQ-025 SHALL accept a new address phase in the DATA or ERR2 cycle (back-to-back, no idle cycle).
REQ-026 SHALL return newly written data to a read issued back-to-back after a write to the same word.

Reset
REQ-027 SHALL on HRESET=1 immediately force state IDLE, HREADY=1, HRSP=0, HRDATA=0.
REQ-028 SHALL abandon an in-flight transfer on reset without committing its write; memory contents SHALL NOT be reset.

Structure
REQ-029 SHALL take ADDR_WIDTH/DATA_WIDTH defaults, htrans_t, hsize_t, hresp_t enums and the FSM state enum from shared package ahb_pkg.
REQ-030 SHALL instantiate one sub-module ahb_slave_mem: DEPTH x 32 array, 4-bit byte-enable write, combinational read.

Verification
REQ-031 SHALL cover: WAIT_STATES=1, word write 0xDEADBEEF @0x00010 then read @0x00010 -> one HREADY-low cycle each, HRDATA=0xDEADBEEF, HRSP=0.
REQ-032 SHALL cover: byte write 0xAA to @0x00013 over word 0x11223344 -> read returns 0xAA223344.
REQ-033 SHALL cover: write @0x00020 with HWDATACHK[0] flipped -> ERR1 then ERR2, HRSP=1 both cycles; subsequent read returns old data.
REQ-034 SHALL cover: DEPTH=1024, access @0x01000 -> two-cycle ERROR without wait cycles; halfword @0x00001 -> ERROR.
REQ-035 SHALL cover: WAIT_STATES=0, back-to-back write then read same word -> HREADY stays 1, read returns written value.
REQ-036 SHALL cover: HRESET asserted during WAIT of a write -> HREADY=1, HRSP=0 same cycle; word unchanged on later read.
